eth_pcs_64_66_encoder: RTL and testbench
========================================

ETH_PCS_64_66_ENCODER -- requirements
Module: eth_pcs_64_66_encoder

Interface
REQ-001 SHALL have port i_clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port i_clk_en, input, 1: gearbox-driven enable; state advances only when high.
REQ-004 SHALL have port i_xgmii_ctrl, input, N_CHANNELS (4): per-lane control flag, lane 0 = bit 0.
REQ-005 SHALL have port i_xgmii_data, input, N_CHANNELS x W_BYTE (32): XGMII lanes, lane 0 = bits [7:0].
REQ-006 SHALL have port o_hdr_valid, output, 1: high on the transfer carrying block half 0.
REQ-007 SHALL have port o_hdr, output, W_SYNC (2): sync header, valid when o_hdr_valid is high.
REQ-008 SHALL have port o_data, output, W_DATA (32): payload half to scrambler, half 0 = payload [31:0].

Function
REQ-009 SHALL count transfers with a 1-bit counter, N_TRANS_PER_BLK = 2, advancing on each enabled cycle and wrapping 1->0.
REQ-010 SHALL capture half 0 on count 0; on count 1 SHALL encode the full 64-bit XGMII word into one 66-bit block and register it.
REQ-011 SHALL present the registered block on the next two enabled cycles: half 0 with o_hdr_valid=1, then half 1 with o_hdr_valid=0; latency is 2 enabled cycles per transfer.
REQ-012 SHALL emit o_hdr=SYNC_DATA and the 64 bits unchanged when all 8 ctrl flags are 0.
REQ-013 SHALL emit SYNC_CTRL with type byte in payload [7:0] for control blocks.
REQ-014 SHALL encode all-control as C_TYPE (0x1E), using 7-bit codes: SYM_IDLE (0x07) -> CODE_IDLE (0x00); anything else -> CODE_ERR (0x1E).
REQ-015 SHALL encode SYM_START (0xFB) in lane 0 with lanes 1-7 data as S0_TYPE (0x78), data in [63:8].
REQ-016 SHALL encode lanes 0-3 control plus SYM_START in lane 4 as S4_TYPE (0x33): four 7-bit codes in [35:8], [39:36]=0, data in [63:40].
REQ-017 SHALL encode SYM_TERM (0xFD) at lane n (0..7) as Tn_TYPE (0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF), with n data bytes packed from bit 8 and the remaining lanes as 7-bit codes.
REQ-018 SHALL encode any other ctrl/data pattern as the E block: C_TYPE with eight CODE_ERR.
REQ-019 SHALL hold all state and outputs when i_clk_en=0.

Reset
REQ-020 On reset, SHALL set counter to 0, o_hdr_valid=0, o_hdr=SYNC_CTRL, o_data=0, state TX_INIT.
REQ-021 After reset release, SHALL treat the first enabled transfer as half 0.
REQ-022 A reset mid-block SHALL discard the captured half 0.

Configuration
REQ-023 With ETH_PCS_TX_SM_EN defined, SHALL run the clause-49 TX state machine (TX_INIT, TX_C, TX_D, TX_T, TX_E) on each encoded block type (C/S/D/T/E).
REQ-024 Transition rules: TX_INIT: C->TX_C, S->TX_D, other->TX_E. TX_C: C->TX_C, S->TX_D, other->TX_E. TX_D: D->TX_D, T->TX_T, other->TX_E. TX_T: C->TX_C, S->TX_D, other->TX_E. TX_E: C->TX_C, D->TX_D, T->TX_T, S->TX_D, E->TX_E.
REQ-025 Any block causing a transition into TX_E SHALL be replaced by the E block.
REQ-026 Without ETH_PCS_TX_SM_EN, SHALL emit per-block encoding only, with no sequence checking.

Structure
REQ-027 SHALL use type codes, SYM_*/CODE_* values, SYNC_* headers, widths and the TX state enum from package eth_pcs_params.
REQ-028 SHALL place per-block encoding in one combinational sub-module, eth_pcs_blk_encode (64b+8 ctrl in -> 2b hdr + 64b payload + block class out).

Verification
REQ-029 Idle stream, ctrl=0xF, data=0x07070707 -> o_hdr=2'b10, half 0 = 0x0000001E, half 1 = 0x00000000.
REQ-030 Lanes 0-7 = FB,55,55,55,55,55,55,D5, ctrl=0x01 -> hdr 10, half 0 = 0x55555578, half 1 = 0xD5555555.
REQ-031 Data 0x03020100/0x07060504, ctrl=0 -> hdr 01, payload passes unchanged; output 2 enabled cycles after each input.
REQ-032 Lanes = AA,BB,CC,FD,07,07,07,07, ctrl=0xF8 -> type 0xB4, payload [31:8]=0xCCBBAA, remaining codes 0.
REQ-033 With ETH_PCS_TX_SM_EN: C block followed directly by a D block -> E block out, state TX_E; a following S block is encoded normally.
REQ-034 i_clk_en toggled 1/0 -> outputs frozen on disabled cycles; reset asserted after half 0 -> no block emitted for that half, o_hdr_valid=0.

Source files
------------

// File: rtl/eth_pcs_64_66_encoder_pkg.sv
// Package eth_pcs_params: widths, sync headers, XGMII control symbols,
// 7-bit control codes, 64b/66b block type bytes, block class and TX state
// enums for the 64b/66b PCS transmit encoder.
// Ports: none (package only).

package eth_pcs_params;

  localparam int N_CHANNELS      = 4;
  localparam int W_BYTE          = 8;
  localparam int W_SYNC          = 2;
  localparam int W_DATA          = N_CHANNELS * W_BYTE;
  localparam int N_TRANS_PER_BLK = 2;
  localparam int N_LANES         = N_CHANNELS * N_TRANS_PER_BLK;
  localparam int W_BLK           = W_DATA * N_TRANS_PER_BLK;
  localparam int W_CODE          = 7;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  localparam logic [W_BYTE-1:0] SYM_IDLE  = 8'h07;
  localparam logic [W_BYTE-1:0] SYM_START = 8'hFB;
  localparam logic [W_BYTE-1:0] SYM_TERM  = 8'hFD;

  localparam logic [W_CODE-1:0] CODE_IDLE = 7'h00;
  localparam logic [W_CODE-1:0] CODE_ERR  = 7'h1E;

  localparam logic [7:0] C_TYPE  = 8'h1E;
  localparam logic [7:0] S0_TYPE = 8'h78;
  localparam logic [7:0] S4_TYPE = 8'h33;
  localparam logic [7:0] T0_TYPE = 8'h87;
  localparam logic [7:0] T1_TYPE = 8'h99;
  localparam logic [7:0] T2_TYPE = 8'hAA;
  localparam logic [7:0] T3_TYPE = 8'hB4;
  localparam logic [7:0] T4_TYPE = 8'hCC;
  localparam logic [7:0] T5_TYPE = 8'hD2;
  localparam logic [7:0] T6_TYPE = 8'hE1;
  localparam logic [7:0] T7_TYPE = 8'hFF;

  // Error block payload: C type with every lane coded as an error.
  localparam logic [W_BLK-1:0] E_PAYLOAD = {{N_LANES{CODE_ERR}}, C_TYPE};

  typedef enum logic [2:0] {
    TX_INIT,
    TX_C,
    TX_D,
    TX_T,
    TX_E
  } tx_state_t;

  typedef enum logic [2:0] {
    BLK_C,
    BLK_S,
    BLK_D,
    BLK_T,
    BLK_E
  } blk_class_t;

  function automatic logic [W_CODE-1:0] ctrl_code(input logic [W_BYTE-1:0] sym);
    return (sym == SYM_IDLE) ? CODE_IDLE : CODE_ERR;
  endfunction

  // Control flags expected when the terminate sits in lane n:
  // lanes below n carry data, lanes n and above carry control.
  function automatic logic [N_LANES-1:0] term_mask(input int n);
    return {N_LANES{1'b1}} << n;
  endfunction

  function automatic logic [7:0] term_type(input logic [2:0] n);
    case (n)
      3'd0:    return T0_TYPE;
      3'd1:    return T1_TYPE;
      3'd2:    return T2_TYPE;
      3'd3:    return T3_TYPE;
      3'd4:    return T4_TYPE;
      3'd5:    return T5_TYPE;
      3'd6:    return T6_TYPE;
      default: return T7_TYPE;
    endcase
  endfunction

endpackage

// File: rtl/eth_pcs_64_66_encoder_blk_encode.sv
// eth_pcs_blk_encode: combinational 64b/66b block encoder.
// Ports:
//   data      in  64  eight XGMII lanes, lane 0 = bits [7:0]
//   ctrl      in  8   per-lane control flags, lane 0 = bit 0
//   hdr       out 2   sync header
//   payload   out 64  block payload, type byte in [7:0] for control blocks
//   blk_class out 3   block class (C/S/D/T/E) for the TX sequence checker

module eth_pcs_blk_encode
  import eth_pcs_params::*;
(
  input  logic [W_BLK-1:0]   data,
  input  logic [N_LANES-1:0] ctrl,
  output logic [W_SYNC-1:0]  hdr,
  output logic [W_BLK-1:0]   payload,
  output blk_class_t         blk_class
);

  logic [N_LANES-1:0][W_BYTE-1:0] lane;
  logic                           t_hit;
  logic [2:0]                     t_pos;

  assign lane = data;

  // Each lane position has a unique ctrl mask, so at most one n can match.
  always_comb begin
    t_hit = 1'b0;
    t_pos = '0;
    for (int n = 0; n < N_LANES; n++) begin
      if (ctrl == term_mask(n) && lane[n] == SYM_TERM) begin
        t_hit = 1'b1;
        t_pos = 3'(n);
      end
    end
  end

  always_comb begin
    hdr       = SYNC_CTRL;
    payload   = E_PAYLOAD;
    blk_class = BLK_E;
    if (ctrl == '0) begin
      hdr       = SYNC_DATA;
      payload   = data;
      blk_class = BLK_D;
    end else if (t_hit) begin
      // Data bytes pack up from bit 8; trailing control codes pack down
      // from bit 63, leaving any zero padding between them.
      blk_class    = BLK_T;
      payload      = '0;
      payload[7:0] = term_type(t_pos);
      for (int i = 0; i < N_LANES - 1; i++) begin
        if (i < int'(t_pos))
          payload[8 + W_BYTE*i +: W_BYTE] = lane[i];
      end
      for (int i = 1; i < N_LANES; i++) begin
        if (i > int'(t_pos))
          payload[W_BLK - W_CODE*(N_LANES - i) +: W_CODE] = ctrl_code(lane[i]);
      end
    end else if (ctrl == 8'h01 && lane[0] == SYM_START) begin
      blk_class = BLK_S;
      payload   = {data[W_BLK-1:8], S0_TYPE};
    end else if (ctrl == 8'h1F && lane[4] == SYM_START) begin
      blk_class    = BLK_S;
      payload      = '0;
      payload[7:0] = S4_TYPE;
      for (int i = 0; i < 4; i++)
        payload[8 + W_CODE*i +: W_CODE] = ctrl_code(lane[i]);
      payload[W_BLK-1:40] = data[W_BLK-1:40];
    end else if (ctrl == '1) begin
      blk_class    = BLK_C;
      payload[7:0] = C_TYPE;
      for (int i = 0; i < N_LANES; i++)
        payload[8 + W_CODE*i +: W_CODE] = ctrl_code(lane[i]);
    end
  end

endmodule

// File: rtl/eth_pcs_64_66_encoder.sv
// eth_pcs_64_66_encoder: 64b/66b PCS transmit encoder fed by a 32-bit XGMII
// interface at two transfers per block. Half 0 is captured, the full word
// is encoded on half 1 and registered, then the block is replayed as two
// 32-bit halves with the sync header flagged on half 0.
// Optional feature: define ETH_PCS_TX_SM_EN to enable the clause-49 TX
// sequence checker, which replaces illegal blocks with the E block.
// Ports:
//   i_clk         in  1   clock, rising edge
//   i_reset_n     in  1   asynchronous active-low reset
//   i_clk_en      in  1   gearbox enable, state advances only when high
//   i_xgmii_ctrl  in  4   per-lane control flags
//   i_xgmii_data  in  32  XGMII lanes, lane 0 = bits [7:0]
//   o_hdr_valid   out 1   high on the transfer carrying block half 0
//   o_hdr         out 2   sync header
//   o_data        out 32  payload half
//
// TX state | meaning (ETH_PCS_TX_SM_EN only)
// ---------+----------------------------------------------
// TX_INIT  | after reset, waiting for a control or start block
// TX_C     | inter-frame control
// TX_D     | inside a frame, data expected
// TX_T     | frame just terminated
// TX_E     | sequence error seen, blocks replaced by E

module eth_pcs_64_66_encoder
  import eth_pcs_params::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clk_en,
  input  logic [N_CHANNELS-1:0] i_xgmii_ctrl,
  input  logic [W_DATA-1:0]     i_xgmii_data,
  output logic                  o_hdr_valid,
  output logic [W_SYNC-1:0]     o_hdr,
  output logic [W_DATA-1:0]     o_data
);

  logic                  cnt_q;
  logic [W_DATA-1:0]     lo_data_q;
  logic [N_CHANNELS-1:0] lo_ctrl_q;

  logic [W_SYNC-1:0]     enc_hdr;
  logic [W_BLK-1:0]      enc_payload;
  blk_class_t            enc_class;
  logic                  blk_replace;

  logic [W_SYNC-1:0]     blk_hdr_q;
  logic [W_BLK-1:0]      blk_payload_q;
  logic                  blk_valid_q;

  eth_pcs_blk_encode u_blk_encode (
    .data      ({i_xgmii_data, lo_data_q}),
    .ctrl      ({i_xgmii_ctrl, lo_ctrl_q}),
    .hdr       (enc_hdr),
    .payload   (enc_payload),
    .blk_class (enc_class)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q     <= 1'b0;
      lo_data_q <= '0;
      lo_ctrl_q <= '0;
    end else if (i_clk_en) begin
      cnt_q <= ~cnt_q;
      if (!cnt_q) begin
        lo_data_q <= i_xgmii_data;
        lo_ctrl_q <= i_xgmii_ctrl;
      end
    end
  end

`ifdef ETH_PCS_TX_SM_EN
  tx_state_t state_q;
  tx_state_t state_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      state_q <= TX_INIT;
    else if (i_clk_en && cnt_q)
      state_q <= state_d;
  end

  always_comb begin
    state_d = TX_E;
    case (state_q)
      TX_INIT, TX_C, TX_T: begin
        case (enc_class)
          BLK_C:   state_d = TX_C;
          BLK_S:   state_d = TX_D;
          default: state_d = TX_E;
        endcase
      end
      TX_D: begin
        case (enc_class)
          BLK_D:   state_d = TX_D;
          BLK_T:   state_d = TX_T;
          default: state_d = TX_E;
        endcase
      end
      TX_E: begin
        case (enc_class)
          BLK_C:   state_d = TX_C;
          BLK_D:   state_d = TX_D;
          BLK_T:   state_d = TX_T;
          BLK_S:   state_d = TX_D;
          default: state_d = TX_E;
        endcase
      end
      default: state_d = TX_E;
    endcase
  end

  assign blk_replace = (state_d == TX_E);
`else
  logic unused_enc_class;

  assign unused_enc_class = ^enc_class;
  assign blk_replace      = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      blk_hdr_q     <= SYNC_CTRL;
      blk_payload_q <= '0;
      blk_valid_q   <= 1'b0;
    end else if (i_clk_en && cnt_q) begin
      blk_valid_q <= 1'b1;
      if (blk_replace) begin
        blk_hdr_q     <= SYNC_CTRL;
        blk_payload_q <= E_PAYLOAD;
      end else begin
        blk_hdr_q     <= enc_hdr;
        blk_payload_q <= enc_payload;
      end
    end
  end

  // Outputs stay at their reset values until the first full block exists,
  // so a half captured before a reset never reaches the output.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hdr_valid <= 1'b0;
      o_hdr       <= SYNC_CTRL;
      o_data      <= '0;
    end else if (i_clk_en && blk_valid_q) begin
      if (!cnt_q) begin
        o_hdr_valid <= 1'b1;
        o_hdr       <= blk_hdr_q;
        o_data      <= blk_payload_q[W_DATA-1:0];
      end else begin
        o_hdr_valid <= 1'b0;
        o_data      <= blk_payload_q[W_BLK-1:W_DATA];
      end
    end
  end

endmodule

// File: tb/tb_eth_pcs_64_66_encoder.sv
// Directed testbench for eth_pcs_64_66_encoder.

module tb_eth_pcs_64_66_encoder;

  logic        i_clk        = 1'b0;
  logic        i_reset_n    = 1'b0;
  logic        i_clk_en     = 1'b0;
  logic [3:0]  i_xgmii_ctrl = '0;
  logic [31:0] i_xgmii_data = '0;
  logic        o_hdr_valid;
  logic [1:0]  o_hdr;
  logic [31:0] o_data;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] IDLE_W = 32'h07070707;
  localparam logic [63:0] S0_D   = 64'hD5555555_555555FB;

  typedef struct packed {
    logic        pre;
    logic [7:0]  c;
    logic [63:0] d;
    logic [1:0]  h;
    logic [31:0] h0;
    logic [31:0] h1;
  } vec_t;

  always #5 i_clk = ~i_clk;

  eth_pcs_64_66_encoder dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clk_en     (i_clk_en),
    .i_xgmii_ctrl (i_xgmii_ctrl),
    .i_xgmii_data (i_xgmii_data),
    .o_hdr_valid  (o_hdr_valid),
    .o_hdr        (o_hdr),
    .o_data       (o_data)
  );

  task automatic xfer(input logic [3:0] c, input logic [31:0] d);
    @(negedge i_clk);
    i_xgmii_ctrl = c;
    i_xgmii_data = d;
    i_clk_en     = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic hold_cycle(input logic [3:0] c, input logic [31:0] d);
    @(negedge i_clk);
    i_xgmii_ctrl = c;
    i_xgmii_data = d;
    i_clk_en     = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_block(input logic [7:0] c, input logic [63:0] d);
    xfer(c[3:0], d[31:0]);
    xfer(c[7:4], d[63:32]);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_clk_en  = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_hdr_valid, o_hdr, o_data} !== {1'b0, 2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b hdr=%b data=%h want v=0 hdr=10 data=00000000",
               o_hdr_valid, o_hdr, o_data);
    end
    @(negedge i_clk);
    i_clk_en  = 1'b0;
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_hdr_valid, o_hdr, o_data} !== {1'b0, 2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL reset_release_idle: got v=%b hdr=%b data=%h want v=0 hdr=10 data=00000000",
               o_hdr_valid, o_hdr, o_data);
    end
  endtask

  task automatic test_encodings();
    vec_t        vecs [10];
    logic [34:0] exp;
    vecs[0] = '{1'b0, 8'hFF, 64'h07070707_07070707, 2'b10, 32'h0000001E, 32'h00000000};
    vecs[1] = '{1'b0, 8'hFF, 64'h07070707_07FE0707, 2'b10, 32'h0780001E, 32'h00000000};
    vecs[2] = '{1'b0, 8'h01, S0_D,                  2'b10, 32'h55555578, 32'hD5555555};
    vecs[3] = '{1'b0, 8'h1F, 64'h332211FB_07070707, 2'b10, 32'h00000033, 32'h33221100};
    vecs[4] = '{1'b1, 8'h00, 64'h07060504_03020100, 2'b01, 32'h03020100, 32'h07060504};
    vecs[5] = '{1'b1, 8'hF8, 64'h07070707_FDCCBBAA, 2'b10, 32'hCCBBAAB4, 32'h00000000};
    vecs[6] = '{1'b1, 8'hFF, 64'h07070707_070707FD, 2'b10, 32'h00000087, 32'h00000000};
    vecs[7] = '{1'b1, 8'h80, 64'hFD776655_44332211, 2'b10, 32'h332211FF, 32'h77665544};
    vecs[8] = '{1'b1, 8'hE0, 64'hFE07FD05_04030201, 2'b10, 32'h030201D2, 32'h3C000504};
    vecs[9] = '{1'b0, 8'h0F, 64'h11223344_07070707, 2'b10, 32'hC78F1E1E, 32'h3C78F1E3};
    for (int k = 0; k < 10; k++) begin
      if (vecs[k].pre)
        send_block(8'h01, S0_D);
      send_block(vecs[k].c, vecs[k].d);
      for (int h = 0; h < 2; h++) begin
        xfer(4'hF, IDLE_W);
        exp = (h == 0) ? {1'b1, vecs[k].h, vecs[k].h0} : {1'b0, vecs[k].h, vecs[k].h1};
        n_cmp++;
        if ({o_hdr_valid, o_hdr, o_data} !== exp) begin
          n_err++;
          $display("FAIL enc[%0d] half%0d: got %h want %h",
                   k, h, {o_hdr_valid, o_hdr, o_data}, exp);
        end
      end
    end
  endtask

  task automatic test_clk_en();
    logic [34:0] exp [6];
    exp[0] = {1'b1, 2'b10, 32'h55555578};
    exp[1] = {1'b1, 2'b10, 32'h55555578};
    exp[2] = {1'b0, 2'b10, 32'hD5555555};
    exp[3] = {1'b0, 2'b10, 32'hD5555555};
    exp[4] = {1'b1, 2'b01, 32'hAAAA5555};
    exp[5] = {1'b0, 2'b01, 32'h12345678};
    send_block(8'h01, S0_D);
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: xfer(4'h0, 32'hAAAA5555);
        1: hold_cycle(4'hF, 32'h0707FDFB);
        2: xfer(4'h0, 32'h12345678);
        3: begin
          hold_cycle(4'h1, 32'hFFFFFFFB);
          hold_cycle(4'h0, 32'h0BADF00D);
        end
        default: xfer(4'hF, IDLE_W);
      endcase
      n_cmp++;
      if ({o_hdr_valid, o_hdr, o_data} !== exp[s]) begin
        n_err++;
        $display("FAIL clk_en step%0d: got %h want %h", s, {o_hdr_valid, o_hdr, o_data}, exp[s]);
      end
    end
  endtask

  task automatic test_sm_sequence();
    logic [34:0] exp [4];
`ifdef ETH_PCS_TX_SM_EN
    exp[0] = {1'b1, 2'b10, 32'hC78F1E1E};
    exp[1] = {1'b0, 2'b10, 32'h3C78F1E3};
`else
    exp[0] = {1'b1, 2'b01, 32'h03020100};
    exp[1] = {1'b0, 2'b01, 32'h07060504};
`endif
    exp[2] = {1'b1, 2'b10, 32'h55555578};
    exp[3] = {1'b0, 2'b10, 32'hD5555555};
    send_block(8'hFF, {IDLE_W, IDLE_W});
    send_block(8'h00, 64'h07060504_03020100);
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       xfer(4'h1, S0_D[31:0]);
        1:       xfer(4'h0, S0_D[63:32]);
        default: xfer(4'hF, IDLE_W);
      endcase
      n_cmp++;
      if ({o_hdr_valid, o_hdr, o_data} !== exp[s]) begin
        n_err++;
        $display("FAIL sm_seq step%0d: got %h want %h", s, {o_hdr_valid, o_hdr, o_data}, exp[s]);
      end
    end
  endtask

  task automatic test_reset_mid_block();
    logic [34:0] exp [4];
    exp[0] = {1'b0, 2'b10, 32'h0};
    exp[1] = {1'b0, 2'b10, 32'h0};
    exp[2] = {1'b1, 2'b10, 32'h0000001E};
    exp[3] = {1'b0, 2'b10, 32'h0};
    xfer(4'h0, 32'hDEADBEEF);
    @(negedge i_clk);
    i_clk_en  = 1'b0;
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_hdr_valid, o_hdr, o_data} !== {1'b0, 2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL mid_reset_async: got %h want %h", {o_hdr_valid, o_hdr, o_data},
               {1'b0, 2'b10, 32'h0});
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      xfer(4'hF, IDLE_W);
      n_cmp++;
      if ({o_hdr_valid, o_hdr, o_data} !== exp[s]) begin
        n_err++;
        $display("FAIL mid_reset step%0d: got %h want %h", s, {o_hdr_valid, o_hdr, o_data}, exp[s]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d compared / %0d mismatched",
             n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encodings();
    test_clk_en();
    test_sm_sequence();
    test_reset_mid_block();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
